cl_axil_mstr: RTL



---
 rtl/cl_axil_mstr_pkg.sv | 29 ++
 rtl/cl_axil_mstr.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cl_axil_mstr_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite master.
// No ports; imported by cl_axil_mstr.
package cl_axil_mstr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      RSP   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        timeout;
   } rsp_t;

endpackage

// File: rtl/cl_axil_mstr.sv
// Single-outstanding AXI4-Lite master. Turns a valid/ready command stream
// (one read or one write per command) into AXI-Lite handshakes and returns
// read data / response status on a valid/ready response stream. A timer
// forces an SLVERR response if the slave stalls; whatever the slave sends
// late is drained and dropped so the bus protocol is never violated.
//
// Ports:
//   clk_main_a0, rst_main      clock, synchronous active-high reset
//   cmd_*                      command stream (wr, addr, wdata, wstrb)
//   rsp_*                      response stream (wr, rdata, resp, timeout)
//   m_axil_aw*/w*/b*/ar*/r*    AXI4-Lite master channels
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | cmd_ready high, nothing pending on the bus
// BUSY  | command issued, waiting for B/R handshake or timeout
// RSP   | response presented on rsp_*, held until rsp_ready
// DRAIN | response delivered, finishing leftover handshakes, data dropped
module cl_axil_mstr
   import cl_axil_mstr_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_main_a0,
   input  logic        rst_main,

   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_wr,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,

   output logic        m_axil_awvalid,
   input  logic        m_axil_awready,
   output logic [31:0] m_axil_awaddr,
   output logic        m_axil_wvalid,
   input  logic        m_axil_wready,
   output logic [31:0] m_axil_wdata,
   output logic [3:0]  m_axil_wstrb,
   input  logic        m_axil_bvalid,
   output logic        m_axil_bready,
   input  logic [1:0]  m_axil_bresp,
   output logic        m_axil_arvalid,
   input  logic        m_axil_arready,
   output logic [31:0] m_axil_araddr,
   input  logic        m_axil_rvalid,
   output logic        m_axil_rready,
   input  logic [31:0] m_axil_rdata,
   input  logic [1:0]  m_axil_rresp
);

   localparam int TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t             state_q, state_d;
   cmd_t               cmd_q;
   rsp_t               rsp_q, rsp_d;
   logic [TMR_W-1:0]   timer_q, timer_d;

   logic aw_pend_q, w_pend_q, b_pend_q, ar_pend_q, r_pend_q;
   logic aw_pend_d, w_pend_d, b_pend_d, ar_pend_d, r_pend_d;
   logic pend_any_d;

   logic accept;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic tmo_hit;

   // Reset gates cmd_ready directly so nothing is accepted in the reset cycle.
   assign cmd_ready = (state_q == IDLE) && !rst_main;
   assign accept    = cmd_valid && cmd_ready;

   assign aw_hs = aw_pend_q && m_axil_awready;
   assign w_hs  = w_pend_q  && m_axil_wready;
   assign b_hs  = b_pend_q  && m_axil_bvalid;
   assign ar_hs = ar_pend_q && m_axil_arready;
   assign r_hs  = r_pend_q  && m_axil_rvalid;

   assign tmo_hit = TMO_EN && (timer_q == TMR_LAST);

   // Each flag clears only on its own channel handshake, so a valid that was
   // raised stays up until the slave takes it, even after a timeout.
   always_comb begin
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      b_pend_d  = b_pend_q;
      ar_pend_d = ar_pend_q;
      r_pend_d  = r_pend_q;
      if (accept) begin
         aw_pend_d = cmd_wr;
         w_pend_d  = cmd_wr;
         b_pend_d  = cmd_wr;
         ar_pend_d = !cmd_wr;
         r_pend_d  = !cmd_wr;
      end else begin
         if (aw_hs) aw_pend_d = 1'b0;
         if (w_hs)  w_pend_d  = 1'b0;
         if (b_hs)  b_pend_d  = 1'b0;
         if (ar_hs) ar_pend_d = 1'b0;
         if (r_hs)  r_pend_d  = 1'b0;
      end
   end

   assign pend_any_d = aw_pend_d || w_pend_d || b_pend_d || ar_pend_d || r_pend_d;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rsp_d   = rsp_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               timer_d = '0;
            end
         end
         BUSY: begin
            if (timer_q != '1) timer_d = timer_q + 1'b1;
            // A real response beats a coincident timeout.
            if (b_hs) begin
               rsp_d   = '{wr: 1'b1, rdata: 32'h0, resp: m_axil_bresp, timeout: 1'b0};
               state_d = RSP;
            end else if (r_hs) begin
               rsp_d   = '{wr: 1'b0, rdata: m_axil_rdata, resp: m_axil_rresp, timeout: 1'b0};
               state_d = RSP;
            end else if (tmo_hit) begin
               rsp_d   = '{wr: cmd_q.wr, rdata: 32'h0, resp: SLVERR, timeout: 1'b1};
               state_d = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) state_d = pend_any_d ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (!pend_any_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_main_a0) begin
      if (rst_main) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         cmd_q     <= '0;
         rsp_q     <= '{wr: 1'b0, rdata: 32'h0, resp: OKAY, timeout: 1'b0};
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         b_pend_q  <= 1'b0;
         ar_pend_q <= 1'b0;
         r_pend_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         rsp_q     <= rsp_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         b_pend_q  <= b_pend_d;
         ar_pend_q <= ar_pend_d;
         r_pend_q  <= r_pend_d;
         if (accept) begin
            cmd_q <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
         end
      end
   end

   assign m_axil_awvalid = aw_pend_q;
   assign m_axil_wvalid  = w_pend_q;
   assign m_axil_bready  = b_pend_q;
   assign m_axil_arvalid = ar_pend_q;
   assign m_axil_rready  = r_pend_q;

   assign m_axil_awaddr  = cmd_q.addr;
   assign m_axil_araddr  = cmd_q.addr;
   assign m_axil_wdata   = cmd_q.wdata;
   assign m_axil_wstrb   = cmd_q.wstrb;

   assign rsp_valid   = (state_q == RSP);
   assign rsp_wr      = rsp_q.wr;
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_resp    = rsp_q.resp;
   assign rsp_timeout = rsp_q.timeout;

endmodule
